// File: rtl/ps2_pkg.sv
// Shared types and scancode prefix constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 lines, debounces ps2_clk with a FILTER_LEN-sample
// filter, and emits a one-cycle strobe on each accepted falling edge.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall,
    output logic dat_sync
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_sync <= 1'b1;
            level    <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2_dat;
            dat_sync <= dat_s1;
            fall     <= 1'b0;
            // cnt counts consecutive samples that disagree with the accepted level
            if (clk_s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= clk_s2;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard frame receiver with F0/E0 prefix tracking.
// Define PS2_TIMEOUT_EN to add an inter-edge timeout that drops stalled frames.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | waiting for a start bit (dat=0 on a fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then decode
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       kdone,
    output logic [7:0] kdata,
    output logic       kbreak,
    output logic       kext,
    output logic       kerr
);

    logic       fall;
    logic       dat;
    ps2_state_t state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       par;
    logic       brk_flag;
    logic       ext_flag;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .fall     (fall),
        .dat_sync (dat)
    );

`ifdef PS2_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TW-1:0] to_cnt;
`else
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            par      <= 1'b0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
            kdone    <= 1'b0;
            kerr     <= 1'b0;
            kdata    <= 8'h00;
            kbreak   <= 1'b0;
            kext     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            kdone <= 1'b0;
            kerr  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            if (state == ST_IDLE || fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (state != ST_IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
                kerr     <= 1'b1;
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
                state    <= ST_IDLE;
            end else
`endif
            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat) begin
                            state   <= ST_DATA;
                            shift   <= '0;
                            bit_cnt <= '0;
                        end else begin
                            kerr     <= 1'b1;
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= dat;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if ((^{shift, par}) && dat) begin
                            if (shift == PS2_BREAK) begin
                                brk_flag <= 1'b1;
                            end else if (shift == PS2_EXT) begin
                                ext_flag <= 1'b1;
                            end else begin
                                kdata    <= shift;
                                kbreak   <= brk_flag;
                                kext     <= ext_flag;
                                kdone    <= 1'b1;
                                brk_flag <= 1'b0;
                                ext_flag <= 1'b0;
                            end
                        end else begin
                            kerr     <= 1'b1;
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 The module SHALL take parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2_clk level.
REQ-002 The module SHALL take parameter TIMEOUT, default 25000: clock cycles allowed between ps2_clk falling edges inside one frame.
REQ-003 clock  input  1  system clock; the only clock in the block.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line from the keyboard, asynchronous.
REQ-006 ps2_dat  input  1  raw PS/2 data line from the keyboard, asynchronous.
REQ-007 kdone  output  1  one-cycle strobe: kdata, kbreak and kext are valid.
REQ-008 kdata  output  8  last accepted scancode byte, held until the next kdone.
REQ-009 kbreak  output  1  an F0 prefix preceded this code (key release).
REQ-010 kext  output  1  an E0 prefix preceded this code (extended key).
REQ-011 kerr  output  1  one-cycle strobe: a frame was dropped (parity, start, stop or timeout error).

Function
REQ-012 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; ps2_clk SHALL also pass through a FILTER_LEN-sample glitch filter. A falling edge SHALL be detected on the filtered clock.
REQ-013 ps2_dat SHALL be sampled, synchronized, on the cycle the filtered falling edge is detected.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP. IDLE->DATA on an edge with dat=0. IDLE with dat=1 on an edge SHALL raise kerr and remain in IDLE.
REQ-015 DATA SHALL shift 8 bits LSB-first; after bit 8 -> PARITY; PARITY -> STOP on the next edge.
REQ-016 On the STOP edge the frame SHALL be accepted only if data^parity has odd parity and stop=1; otherwise kerr SHALL pulse and the byte SHALL be discarded. The FSM SHALL return to IDLE in both cases.
REQ-017 An accepted byte 8'hF0 SHALL set the internal break flag; 8'hE0 SHALL set the extended flag; neither SHALL pulse kdone.
REQ-018 Any other accepted byte SHALL, on the cycle after the stop edge, load kdata, copy the flags to kbreak/kext, pulse kdone for exactly 1 cycle, and clear both internal flags.
REQ-019 Latency: kdone SHALL be asserted exactly 1 clock after the cycle in which the stop-bit falling edge is detected.
REQ-020 kerr SHALL also clear both internal prefix flags. kerr and kdone SHALL never be asserted in the same cycle.
REQ-021 Back-to-back frames SHALL be accepted with no dead time beyond the return to IDLE.

Reset
REQ-022 Reset SHALL force: FSM IDLE, shift register 0, bit counter 0, internal flags 0, kdone 0, kerr 0, kdata 8'h00, kbreak 0, kext 0, filter and synchronizers 1 (bus idle), timeout counter 0.
REQ-023 Reset mid-frame SHALL drop the partial frame without pulsing kdone or kerr. After release, decoding SHALL resume with the next start bit.

Configuration
REQ-024 With PS2_TIMEOUT_EN defined, a counter SHALL run while not in IDLE and clear on each filtered falling edge. On reaching TIMEOUT-1 it SHALL pulse kerr, clear the prefix flags and return to IDLE.
REQ-025 Without PS2_TIMEOUT_EN, no counter SHALL exist, a stalled frame SHALL wait indefinitely, and the TIMEOUT parameter SHALL be ignored.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state typedef and the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
REQ-027 Sub-module ps2_filter SHALL contain the synchronizer, the glitch filter and the falling-edge detect, and output a one-cycle fall strobe and the synchronized data.

Verification
REQ-028 Frame with byte 8'h1C, parity 0, stop 1 -> one kdone, kdata=8'h1C, kbreak=0, kext=0, kerr=0.
REQ-029 Frames F0 then 1C -> no kdone after F0; one kdone with kdata=8'h1C, kbreak=1, kext=0.
REQ-030 Frames E0, F0, 75 -> single kdone with kdata=8'h75, kbreak=1, kext=1; the next plain 8'h75 frame -> kbreak=0, kext=0.
REQ-031 Frame 8'h1C with parity bit 1 -> kerr pulse, no kdone, kdata unchanged.
REQ-032 1-cycle glitches on ps2_clk mid-frame (FILTER_LEN=8) -> no extra bits; byte 8'h5A decoded correctly.
REQ-033 With PS2_TIMEOUT_EN and TIMEOUT=1000, stop clocking after 4 data bits -> kerr at cycle 1000 after the last edge; a following valid 8'h29 frame decodes correctly.
